// File: rtl/pattern_merge_pkg.sv
// Shared types and helpers for the pattern merge pipeline.
package pattern_merge_pkg;

  // Widest channel that the left-pattern helper can reduce.
  localparam int unsigned LP_MAX_W = 64;

  // Payload bits carried per channel: one each of nand, nor and parity.
  localparam int PAYLOAD_PER_CH = 3;

  // g78 update rule encodings.
  localparam int MODE_TOGGLE = 0;
  localparam int MODE_STICKY = 1;

  typedef struct packed {
    logic nand_b;
    logic nor_b;
    logic par_b;
  } left_t;

  // Left-pattern triple over the low w bits of d; bits above w are masked
  // so that they act as the identity element of each reduction.
  function automatic left_t left_pattern(input logic [LP_MAX_W-1:0] d,
                                         input int unsigned w);
    logic [LP_MAX_W-1:0] mask;
    left_t r;
    mask     = (w >= LP_MAX_W) ? '1 : ((LP_MAX_W'(1) << w) - LP_MAX_W'(1));
    r.nand_b = ~&(d | ~mask);
    r.nor_b  = ~|(d & mask);
    r.par_b  = ^(d & mask);
    return r;
  endfunction

endpackage

// File: rtl/pattern_merge_stage.sv
// One elastic ready/valid register stage. It loads whenever it is empty or
// its current beat is being drained, so bubbles collapse.
module pattern_merge_stage #(
  parameter int PW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [PW-1:0] up_data,
  input  logic          drain,
  output logic          ready,
  output logic          valid,
  output logic [PW-1:0] data
);

  assign ready = ~valid | drain;

  // Stage register: take the upstream beat (or a bubble) when ready.
  always_ff @(posedge clk) begin
    // NOTE: state uses <= so every stage samples the pre-edge values of its
    // neighbours; blocking here would ripple a beat through several stages.
    if (rst) begin
      valid <= 1'b0;
      // NOTE: the payload is reset too, so a discarded beat leaves no trace
      // and the merge outputs start from a known value.
      data  <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/pattern_merge_pipe.sv
// Per-channel left-pattern reduction, DEPTH-stage elastic pipeline and a
// right-pattern merge feeding a stateful flag and saturating counter.
import pattern_merge_pkg::*;

module pattern_merge_pipe #(
  parameter int W     = 4,
  parameter int CH    = 2,
  parameter int DEPTH = 2,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic            blif_clk_net,
  input  logic            blif_reset_net,
  input  logic [CH*W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            clr,
  input  logic            out_ready,
  output logic            out_valid,
  output logic            merge_and,
  output logic            merge_or,
  output logic            merge_par,
  output logic            g78,
  output logic [CNT_W-1:0] count
);

  localparam int PAYLOAD_W = PAYLOAD_PER_CH * CH;

  logic [CH-1:0]        nand_v, nor_v, par_v;
  left_t                lp;
  logic [DEPTH-1:0]     v, rdy, drn;
  logic [PAYLOAD_W-1:0] pl [DEPTH];
  logic [PAYLOAD_W-1:0] last;
  logic                 xfer;

  // Left pattern on every input channel.
  always_comb begin
    // NOTE: defaults first so no path through the block can infer a latch.
    nand_v = '0;
    nor_v  = '0;
    par_v  = '0;
    lp     = '0;
    for (int c = 0; c < CH; c++) begin
      lp        = left_pattern(LP_MAX_W'(in_data[c*W +: W]), W);
      nand_v[c] = lp.nand_b;
      nor_v[c]  = lp.nor_b;
      par_v[c]  = lp.par_b;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                 up_valid;
    logic [PAYLOAD_W-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = {par_v, nor_v, nand_v};
    end else begin : g_body
      assign up_valid = v[k-1];
      assign up_data  = pl[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign drn[k] = xfer;
    end else begin : g_mid
      assign drn[k] = v[k] & rdy[k+1];
    end

    pattern_merge_stage #(.PW(PAYLOAD_W)) u_stage (
      .clk      (blif_clk_net),
      .rst      (blif_reset_net),
      .up_valid (up_valid),
      .up_data  (up_data),
      .drain    (drn[k]),
      .ready    (rdy[k]),
      .valid    (v[k]),
      .data     (pl[k])
    );
  end

  assign last      = pl[DEPTH-1];
  assign in_ready  = rdy[0] & ~blif_reset_net;
  assign out_valid = v[DEPTH-1] & ~blif_reset_net;
  assign xfer      = out_valid & out_ready;

  assign merge_and = out_valid & (&last[CH-1:0]);
  assign merge_or  = out_valid & (|last[2*CH-1:CH]);
  assign merge_par = out_valid & (^last[3*CH-1:2*CH]);

  // Flag and transfer counter; clr beats a simultaneous transfer.
  always_ff @(posedge blif_clk_net) begin
    if (blif_reset_net || clr) begin
      g78   <= 1'b0;
      count <= '0;
    end else if (xfer) begin
      if (MODE == MODE_STICKY) g78 <= g78 | merge_or;
      else                     g78 <= g78 ^ merge_par;
      if (count != '1) count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pattern_merge_pipe.sv
// Directed bench: one default instance (toggle mode, 8-bit count) and one
// sticky-mode instance with a 2-bit count, driven by the same stimulus.
module tb_pattern_merge_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, clr, out_ready;

  logic       a_in_ready, a_out_valid, a_and, a_or, a_par, a_g78;
  logic [7:0] a_count;
  logic       b_in_ready, b_out_valid, b_and, b_or, b_par, b_g78;
  logic [1:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pattern_merge_pipe dut_a (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (a_in_ready),
    .clr            (clr),
    .out_ready      (out_ready),
    .out_valid      (a_out_valid),
    .merge_and      (a_and),
    .merge_or       (a_or),
    .merge_par      (a_par),
    .g78            (a_g78),
    .count          (a_count)
  );

  pattern_merge_pipe #(.MODE(1), .CNT_W(2)) dut_b (
    .blif_clk_net   (clk),
    .blif_reset_net (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (b_in_ready),
    .clr            (clr),
    .out_ready      (out_ready),
    .out_valid      (b_out_valid),
    .merge_and      (b_and),
    .merge_or       (b_or),
    .merge_par      (b_par),
    .g78            (b_g78),
    .count          (b_count)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_merge_or", a_or, 0);
    tick(); tick();
    rst = 1'b0; #1;
    check("post_rst_in_ready", a_in_ready, 1);
    check("post_rst_count", a_count, 0);
    check("post_rst_g78", a_g78, 0);

    // Single beat 0F: latency two cycles.
    in_data = 8'h0F; in_valid = 1'b1; #1;
    check("a_accept_ready", a_in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    check("a_lat_t1", a_out_valid, 0);
    tick(); #1;
    check("a_lat_t2", a_out_valid, 1);
    check("a_and", a_and, 0);
    check("a_or", a_or, 1);
    check("a_par", a_par, 0);
    tick(); #1;
    check("a_drained", a_out_valid, 0);
    check("a_count", a_count, 1);
    check("a_g78", a_g78, 0);
    check("a_b_g78", b_g78, 1);
    check("a_b_count", b_count, 1);
    clr = 1'b1; tick(); clr = 1'b0; #1;
    check("clr_count", a_count, 0);
    check("clr_b_g78", b_g78, 0);

    // Back-to-back 01, 03, 07 in toggle mode.
    in_data = 8'h01; in_valid = 1'b1; tick();
    in_data = 8'h03; tick();
    in_data = 8'h07; #1;
    check("b2b_valid0", a_out_valid, 1);
    check("b2b_par0", a_par, 1);
    tick(); in_valid = 1'b0; #1;
    check("b2b_par1", a_par, 0);
    check("b2b_g78_1", a_g78, 1);
    tick(); #1;
    check("b2b_par2", a_par, 1);
    check("b2b_g78_2", a_g78, 1);
    tick(); #1;
    check("b2b_empty", a_out_valid, 0);
    check("b2b_g78_3", a_g78, 0);
    check("b2b_count", a_count, 3);
    check("b2b_b_count_sat", b_count, 3);
    check("b2b_b_g78", b_g78, 1);
    clr = 1'b1; tick(); clr = 1'b0;

    // Stall: three beats against out_ready=0.
    out_ready = 1'b0;
    in_data = 8'h01; in_valid = 1'b1; #1;
    check("stall_rdy0", a_in_ready, 1);
    tick(); in_data = 8'h0F; #1;
    check("stall_rdy1", a_in_ready, 1);
    tick(); in_data = 8'hFF; #1;
    check("stall_full", a_in_ready, 0);
    check("stall_valid", a_out_valid, 1);
    tick(); #1;
    check("stall_hold_rdy", a_in_ready, 0);
    check("stall_hold_and", a_and, 1);
    check("stall_hold_or", a_or, 1);
    check("stall_hold_par", a_par, 1);
    out_ready = 1'b1; #1;
    check("release_rdy", a_in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    check("rel_b2_valid", a_out_valid, 1);
    check("rel_b2_and", a_and, 0);
    check("rel_b2_or", a_or, 1);
    check("rel_b2_par", a_par, 0);
    tick(); #1;
    check("rel_b3_valid", a_out_valid, 1);
    check("rel_b3_or", a_or, 0);
    check("rel_b3_and", a_and, 0);
    tick(); #1;
    check("rel_empty", a_out_valid, 0);
    check("rel_count", a_count, 3);
    check("rel_g78", a_g78, 1);
    clr = 1'b1; tick(); clr = 1'b0;

    // Sticky mode, then clr colliding with a transfer.
    in_data = 8'h00; in_valid = 1'b1; tick();
    in_data = 8'hFF; tick();
    in_data = 8'h01; #1;
    check("sticky_or0", b_or, 1);
    tick(); in_valid = 1'b0; #1;
    check("sticky_g78_0", b_g78, 1);
    check("sticky_or1", b_or, 0);
    tick(); #1;
    check("sticky_g78_1", b_g78, 1);
    check("sticky_valid2", b_out_valid, 1);
    clr = 1'b1; tick(); clr = 1'b0; #1;
    check("clrT_g78", b_g78, 0);
    check("clrT_b_count", b_count, 0);
    check("clrT_a_count", a_count, 0);
    check("clrT_consumed", a_out_valid, 0);

    // Saturation of the 2-bit counter over five transfers.
    for (int i = 0; i < 8; i++) begin
      in_data = 8'h00; in_valid = (i < 5); #1;
      if (i >= 3) check($sformatf("sat_%0d", i), b_count, (i - 2 > 3) ? 3 : i - 2);
      tick();
    end
    #1;
    check("sat_a_count", a_count, 5);
    check("sat_b_count", b_count, 3);

    // Reset with two beats in flight.
    in_data = 8'h01; in_valid = 1'b1; tick(); tick();
    in_valid = 1'b0; rst = 1'b1; #1;
    check("midrst_valid", a_out_valid, 0);
    check("midrst_ready", a_in_ready, 0);
    check("midrst_and", a_and, 0);
    tick(); rst = 1'b0; #1;
    check("midrst_after_valid", a_out_valid, 0);
    check("midrst_count", a_count, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check($sformatf("midrst_nobeat_%0d", i), a_out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
